latch_bank_ctrl: RTL and testbench



---
 rtl/latch_bank_pkg.sv | 28 ++
 rtl/latch_phase_timer.sv | 27 ++
 rtl/latch_bank_ctrl.sv | 132 +++++++++++++
 tb/tb_latch_bank_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/latch_bank_pkg.sv
// rtl/latch_bank_pkg.sv - shared state encoding, timing defaults and counter sizing
package latch_bank_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    ACK   = 3'd4
  } state_t;

  localparam int DEF_W       = 8;
  localparam int DEF_N       = 4;
  localparam int DEF_AW      = 2;
  localparam int DEF_T_SETUP = 1;
  localparam int DEF_T_PULSE = 2;
  localparam int DEF_T_HOLD  = 1;

  // Width that holds the largest phase length minus one, plus one spare bit
  function automatic int cnt_width(input int t_setup, input int t_pulse, input int t_hold);
    int m;
    m = t_setup;
    if (t_pulse > m) m = t_pulse;
    if (t_hold > m) m = t_hold;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/latch_phase_timer.sv
// rtl/latch_phase_timer.sv - loadable down-counter shared by the timed phases
module latch_phase_timer #(
  parameter int CW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] count;

  // Load on phase entry, otherwise count down and rest at zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/latch_bank_ctrl.sv
// rtl/latch_bank_ctrl.sv - req/ack write sequencer framing latch enables with setup and hold
module latch_bank_ctrl
  import latch_bank_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int N       = DEF_N,
  parameter int AW      = DEF_AW,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  data,
  output logic          ack,
  output logic          err,
  output logic          busy,
  output logic [W-1:0]  d_out,
  output logic [N-1:0]  c_out
);

  localparam int            CW       = cnt_width(T_SETUP, T_PULSE, T_HOLD);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [AW:0]   N_L      = (AW + 1)'(N);

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic            addr_bad;
  logic [N-1:0]    sel;
  logic            load;
  logic [CW-1:0]   load_val;
  logic            done;

  // An address past the last word still runs the full timing but never opens a latch
  assign addr_bad = ({1'b0, addr_q} >= N_L);

  // One-hot enable pattern for the captured address
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (!addr_bad && (addr_q == AW'(i))) sel[i] = 1'b1;
    end
  end

  // Reload the phase timer on entry to each timed state
  always_comb begin
    load     = 1'b0;
    load_val = LD_SETUP;
    case (state)
      IDLE:  load = req;
      SETUP: begin
        load     = done;
        load_val = LD_PULSE;
      end
      PULSE: begin
        load     = done;
        load_val = LD_HOLD;
      end
      default: load = 1'b0;
    endcase
  end

  latch_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  // Sequencer with all bank-facing and handshake outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      d_out  <= '0;
      c_out  <= '0;
      ack    <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state  <= SETUP;
            addr_q <= addr;
            d_out  <= data;
            busy   <= 1'b1;
          end
        end
        SETUP: begin
          if (done) begin
            state <= PULSE;
            c_out <= sel;
          end
        end
        PULSE: begin
          if (done) begin
            state <= HOLD;
            c_out <= '0;
          end
        end
        HOLD: begin
          if (done) begin
            state <= ACK;
            ack   <= 1'b1;
            err   <= addr_bad;
          end
        end
        ACK: begin
          if (!req) begin
            state <= IDLE;
            ack   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          c_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb/tb_latch_bank_ctrl.sv - randomized bench with elapsed-time reference model and latch bank
module tb_latch_bank_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       req[2];
  logic [1:0] addr[2];
  logic [7:0] data[2];

  logic       ack_a, err_a, busy_a, ack_b, err_b, busy_b;
  logic [7:0] d_a, d_b;
  logic [3:0] c_a;
  logic [2:0] c_b;

  latch_bank_ctrl u_a (
    .clock (clock), .reset (reset), .req (req[0]), .addr (addr[0]), .data (data[0]),
    .ack (ack_a), .err (err_a), .busy (busy_a), .d_out (d_a), .c_out (c_a)
  );

  latch_bank_ctrl #(
    .W(8), .N(3), .AW(2), .T_SETUP(3), .T_PULSE(1), .T_HOLD(2)
  ) u_b (
    .clock (clock), .reset (reset), .req (req[1]), .addr (addr[1]), .data (data[1]),
    .ack (ack_b), .err (err_b), .busy (busy_b), .d_out (d_b), .c_out (c_b)
  );

  // behavioural latch banks
  logic [7:0] bank_a[4] = '{default: 8'h00};
  logic [7:0] bank_b[3] = '{default: 8'h00};
  always @(c_a or d_a) for (int j = 0; j < 4; j++) if (c_a[j]) bank_a[j] = d_a;
  always @(c_b or d_b) for (int j = 0; j < 3; j++) if (c_b[j]) bank_b[j] = d_b;

  function automatic logic       ack_of(int i);  return i == 0 ? ack_a : ack_b; endfunction
  function automatic logic       err_of(int i);  return i == 0 ? err_a : err_b; endfunction
  function automatic logic       busy_of(int i); return i == 0 ? busy_a : busy_b; endfunction
  function automatic logic [7:0] d_of(int i);    return i == 0 ? d_a : d_b; endfunction
  function automatic logic [3:0] c_of(int i);    return i == 0 ? c_a : {1'b0, c_b}; endfunction
  function automatic logic [7:0] bank_of(int i, int j);
    return i == 0 ? bank_a[j] : bank_b[j];
  endfunction

  // reference model: elapsed edges since acceptance decide every output
  int         TS[2] = '{1, 3};
  int         TP[2] = '{2, 1};
  int         TH[2] = '{1, 2};
  int         NN[2] = '{4, 3};
  bit         m_busy[2] = '{0, 0};
  int         m_t[2] = '{0, 0};
  int         m_addr[2] = '{0, 0};
  logic [7:0] m_d[2] = '{8'h00, 8'h00};
  logic [7:0] mem[2][4] = '{default: 8'h00};
  bit         vld[2][4] = '{default: 1'b1};

  int vecs = 0;
  int errs = 0;
  bit run = 0;

  function automatic int lat_of(int i); return TS[i] + TP[i] + TH[i]; endfunction
  function automatic bit in_pulse(int i);
    return m_busy[i] && m_t[i] >= TS[i] && m_t[i] < TS[i] + TP[i] && m_addr[i] < NN[i];
  endfunction
  function automatic logic [3:0] exp_c(int i);
    return in_pulse(i) ? 4'(1 << m_addr[i]) : 4'b0000;
  endfunction
  function automatic bit exp_ack(int i);
    return m_busy[i] && m_t[i] >= lat_of(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (in_pulse(i)) vld[i][m_addr[i]] = 1'b0;
        m_busy[i] = 1'b0;
        m_t[i]    = 0;
        m_d[i]    = 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (req[i] === 1'b1) begin
            m_busy[i] = 1'b1;
            m_t[i]    = 0;
            m_addr[i] = int'(addr[i]);
            m_d[i]    = data[i];
          end
        end else if (m_t[i] >= lat_of(i) && req[i] === 1'b0) begin
          m_busy[i] = 1'b0;
        end else begin
          m_t[i]++;
        end
        if (exp_c(i) != 4'b0000) begin
          mem[i][m_addr[i]] = m_d[i];
          vld[i][m_addr[i]] = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (run && !reset) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), busy_of(i), m_busy[i]);
        chk($sformatf("ack%0d", i), ack_of(i), exp_ack(i));
        chk($sformatf("err%0d", i), err_of(i), exp_ack(i) && m_addr[i] >= NN[i]);
        chk($sformatf("c_out%0d", i), c_of(i), exp_c(i));
        chk($sformatf("d_out%0d", i), d_of(i), m_d[i]);
        for (int j = 0; j < NN[i]; j++)
          if (vld[i][j]) chk($sformatf("word%0d_%0d", i, j), bank_of(i, j), mem[i][j]);
      end
    end
  end

  task automatic write(input int i, input int a, input logic [7:0] dv, input int extra,
                       input bit chg, output int lat, output int pw, output logic e);
    lat = -1;
    pw  = 0;
    e   = 1'b0;
    req[i]  = 1'b1;
    addr[i] = a[1:0];
    data[i] = dv;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (chg && n >= 2) begin
        data[i] = 8'h3C;
        addr[i] = ~a[1:0];
      end
      if (c_of(i) != 4'b0000) pw++;
      if (ack_of(i)) begin
        lat = n - 1;
        e   = err_of(i);
        break;
      end
    end
    chk("ack_seen", lat >= 0, 1);
    for (int n = 0; n < extra; n++) begin
      @(negedge clock);
      chk("ack_held", ack_of(i), 1);
    end
    req[i] = 1'b0;
    @(negedge clock);
    chk("ack_fall", ack_of(i), 0);
    chk("busy_fall", busy_of(i), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pw, ii, aa, ex;
    logic e;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = 2'd0; data[i] = 8'h00;
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    run = 1;
    @(negedge clock);
    chk("rst_busy", busy_a, 0);
    chk("rst_ack", ack_a, 0);
    chk("rst_c", c_a, 4'b0000);
    chk("rst_d", d_a, 8'h00);

    write(0, 2, 8'hA5, 0, 0, lat, pw, e);
    chk("t1_latency", lat, 4);
    chk("t1_pulse_width", pw, 2);
    chk("t1_word2", bank_a[2], 8'hA5);
    chk("t1_word0", bank_a[0], 8'h00);
    chk("t1_word1", bank_a[1], 8'h00);
    chk("t1_word3", bank_a[3], 8'h00);

    write(0, 1, 8'hA5, 0, 1, lat, pw, e);
    chk("t2_dout_kept", d_a, 8'hA5);
    chk("t2_word1", bank_a[1], 8'hA5);

    write(1, 3, 8'h77, 0, 0, lat, pw, e);
    chk("t3_err", e, 1);
    chk("t3_no_pulse", pw, 0);
    chk("t3_latency", lat, 6);
    chk("t3_words", {bank_b[0], bank_b[1], bank_b[2]}, 24'h000000);

    write(0, 0, 8'h5A, 5, 0, lat, pw, e);
    chk("t4_word0", bank_a[0], 8'h5A);

    for (int k = 0; k < 2; k++) begin
      write(1, 2 * k, 8'h11 * (k + 1), 0, 0, lat, pw, e);
      chk("t5_latency", lat, 6);
      chk("t5_pulse_width", pw, 1);
    end
    chk("t5_word2", bank_b[2], 8'h22);

    for (int k = 0; k < 30; k++) begin
      ii = $urandom_range(0, 1);
      aa = $urandom_range(0, 3);
      ex = $urandom_range(0, 3);
      write(ii, aa, 8'($urandom), ex, 1'($urandom_range(0, 1)), lat, pw, e);
      chk("rand_latency", lat, ii == 0 ? 4 : 6);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    req[0] = 1'b1; addr[0] = 2'd3; data[0] = 8'hC3;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (c_a != 4'b0000) break;
    end
    chk("r_reach_pulse", c_a, 4'b1000);
    #1 reset = 1'b1;
    #1;
    chk("r_c", c_a, 4'b0000);
    chk("r_d", d_a, 8'h00);
    chk("r_ack", ack_a, 0);
    chk("r_busy", busy_a, 0);
    req[0] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("r_idle_after", busy_a, 0);
    write(0, 3, 8'h96, 0, 0, lat, pw, e);
    chk("r_recover_lat", lat, 4);
    chk("r_recover_word", bank_a[3], 8'h96);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
